// File: rtl/tile_access_arbiter_pkg.sv
// rtl/tile_access_arbiter_pkg.sv - shared maze geometry, field widths and state/direction encodings
package tile_access_arbiter_pkg;

    localparam int tile_size    = 20;
    localparam int tile_col_num = 32;
    localparam int tile_row_num = 24;

    localparam int X_W   = 10;
    localparam int Y_W   = 9;
    localparam int DIR_W = 2;
    localparam int CNT_W = 10;

    typedef enum logic [DIR_W-1:0] {
        dir_up    = 2'd0,
        dir_down  = 2'd1,
        dir_left  = 2'd2,
        dir_right = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_LOOKUP  = 2'd2,
        ST_RESPOND = 2'd3
    } state_e;

endpackage

// File: rtl/tile_access_arbiter_if.sv
// rtl/tile_access_arbiter_if.sv - lookup request/response bus between movers and the tile arbiter
interface tile_access_arbiter_if #(
    parameter int NUM_REQ = 5
);
    import tile_access_arbiter_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*X_W-1:0]   req_x;
    logic [NUM_REQ*Y_W-1:0]   req_y;
    logic [NUM_REQ*DIR_W-1:0] req_dir;
    logic                     req_eat;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic                     rsp_wall;
    logic                     rsp_dot;

    modport master (
        output req, req_x, req_y, req_dir, req_eat,
        input  grant, rsp_valid, rsp_wall, rsp_dot
    );

    modport slave (
        input  req, req_x, req_y, req_dir, req_eat,
        output grant, rsp_valid, rsp_wall, rsp_dot
    );

endinterface

// File: rtl/tile_access_arbiter_rr_picker.sv
// rtl/tile_access_arbiter_rr_picker.sv - round-robin select: first requester after the pointer, wrapping
module tile_access_arbiter_rr_picker #(
    parameter int NUM_REQ = 5,
    parameter int PTR_W   = 3
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [PTR_W-1:0]   idx_o,
    output logic               any_o
);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Scan ptr+1 .. ptr+NUM_REQ so the last winner has the lowest priority.
    always_comb begin
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!any_o && req_i[cand_idx]) begin
                any_o = 1'b1;
                idx_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/tile_access_arbiter.sv
// rtl/tile_access_arbiter.sv - maze tilemap owner: dot-map load scan and round-robin wall/dot lookups
module tile_access_arbiter
    import tile_access_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 5,
    parameter int TILE_SIZE = tile_size,
    parameter int COLS      = tile_col_num,
    parameter int ROWS      = tile_row_num
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_level,
    tile_access_arbiter_if.slave bus,
    input  logic [ROWS*COLS-1:0] tilemap_walls,
    output logic [ROWS*COLS-1:0] tilemap_dots,
    output logic [CNT_W-1:0]     dots_remaining,
    output logic                 level_clear,
    output logic                 busy_loading
);

    localparam int NT    = ROWS * COLS;
    localparam int IDX_W = $clog2(NT);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [NT-1:0]    dots_q, dots_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    dir_e             dir_q, dir_d;
    logic             eat_q, eat_d;
    logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
    logic             cur_ok_q, cur_ok_d;
    logic             wall_q, wall_d;
    logic             dot_q, dot_d;
    logic             load_pend_q, load_pend_d;
    logic             level_clear_q, level_clear_d;

    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic             start_load;

    logic [X_W-1:0]   lk_col, nb_col;
    logic [Y_W-1:0]   lk_row, nb_row;
    logic             lk_ok, nb_off, lk_wall, lk_dot;
    logic [IDX_W-1:0] lk_idx, nb_idx;

    function automatic logic [IDX_W-1:0] tile_index(input logic [Y_W-1:0] r, input logic [X_W-1:0] c);
        return IDX_W'(r) * IDX_W'(COLS) + IDX_W'(c);
    endfunction

    tile_access_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req_i (bus.req),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A load_level pulse that lands mid-lookup is remembered and honoured in IDLE.
    assign start_load = load_level | load_pend_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (!load_level && scan_q == IDX_W'(NT - 1)) state_d = ST_IDLE;
            ST_IDLE:    if (start_load) state_d = ST_LOAD;
                        else if (pick_any) state_d = ST_LOOKUP;
            ST_LOOKUP:  state_d = ST_RESPOND;
            ST_RESPOND: state_d = ST_IDLE;
            default:    state_d = ST_LOAD;
        endcase
    end

    // Off-grid current tiles and off-grid neighbours both read as walls.
    always_comb begin
        lk_col = x_q / X_W'(TILE_SIZE);
        lk_row = y_q / Y_W'(TILE_SIZE);
        lk_ok  = (lk_col < X_W'(COLS)) && (lk_row < Y_W'(ROWS));
        nb_col = lk_col;
        nb_row = lk_row;
        nb_off = !lk_ok;
        case (dir_q)
            dir_up: begin
                nb_off = nb_off | (lk_row == '0);
                nb_row = lk_row - Y_W'(1);
            end
            dir_down: begin
                nb_off = nb_off | (lk_row == Y_W'(ROWS - 1));
                nb_row = lk_row + Y_W'(1);
            end
            dir_left: begin
                nb_off = nb_off | (lk_col == '0);
                nb_col = lk_col - X_W'(1);
            end
            default: begin
                nb_off = nb_off | (lk_col == X_W'(COLS - 1));
                nb_col = lk_col + X_W'(1);
            end
        endcase
        lk_idx  = tile_index(lk_row, lk_col);
        nb_idx  = tile_index(nb_row, nb_col);
        lk_wall = nb_off || tilemap_walls[nb_idx];
        lk_dot  = lk_ok && dots_q[lk_idx];
    end

    always_comb begin
        scan_d      = scan_q;
        dots_d      = dots_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        eat_d       = eat_q;
        cur_idx_d   = cur_idx_q;
        cur_ok_d    = cur_ok_q;
        wall_d      = wall_q;
        dot_d       = dot_q;
        load_pend_d = load_pend_q;
        case (state_q)
            ST_LOAD: begin
                if (load_level) begin
                    scan_d = '0;
                    cnt_d  = '0;
                    dots_d = '0;
                end else begin
                    dots_d[scan_q] = ~tilemap_walls[scan_q];
                    if (!tilemap_walls[scan_q]) cnt_d = cnt_q + CNT_W'(1);
                    scan_d = (scan_q == IDX_W'(NT - 1)) ? '0 : scan_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (start_load) begin
                    scan_d      = '0;
                    cnt_d       = '0;
                    dots_d      = '0;
                    load_pend_d = 1'b0;
                end else if (pick_any) begin
                    rr_ptr_d = pick_idx;
                    x_d      = bus.req_x[int'(pick_idx)*X_W +: X_W];
                    y_d      = bus.req_y[int'(pick_idx)*Y_W +: Y_W];
                    dir_d    = dir_e'(bus.req_dir[int'(pick_idx)*DIR_W +: DIR_W]);
                    eat_d    = bus.req_eat && (pick_idx == '0);
                end
            end
            ST_LOOKUP: begin
                cur_idx_d = lk_idx;
                cur_ok_d  = lk_ok;
                wall_d    = lk_wall;
                dot_d     = lk_dot;
                if (load_level) load_pend_d = 1'b1;
            end
            default: begin
                if (load_level) load_pend_d = 1'b1;
                if (eat_q && cur_ok_q && dots_q[cur_idx_q]) begin
                    dots_d[cur_idx_q] = 1'b0;
                    if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
        level_clear_d = (state_q != ST_LOAD) && (state_d != ST_LOAD) && (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_q        <= '0;
            dots_q        <= '0;
            cnt_q         <= '0;
            rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
            x_q           <= '0;
            y_q           <= '0;
            dir_q         <= dir_up;
            eat_q         <= 1'b0;
            cur_idx_q     <= '0;
            cur_ok_q      <= 1'b0;
            wall_q        <= 1'b0;
            dot_q         <= 1'b0;
            load_pend_q   <= 1'b0;
            level_clear_q <= 1'b0;
        end else begin
            scan_q        <= scan_d;
            dots_q        <= dots_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dir_q         <= dir_d;
            eat_q         <= eat_d;
            cur_idx_q     <= cur_idx_d;
            cur_ok_q      <= cur_ok_d;
            wall_q        <= wall_d;
            dot_q         <= dot_d;
            load_pend_q   <= load_pend_d;
            level_clear_q <= level_clear_d;
        end
    end

    always_comb begin
        busy_loading  = (state_q == ST_LOAD);
        bus.grant     = '0;
        bus.rsp_valid = '0;
        bus.rsp_wall  = 1'b0;
        bus.rsp_dot   = 1'b0;
        if (state_q == ST_LOOKUP) begin
            bus.grant[rr_ptr_q] = 1'b1;
        end
        if (state_q == ST_RESPOND) begin
            bus.rsp_valid[rr_ptr_q] = 1'b1;
            bus.rsp_wall            = wall_q;
            bus.rsp_dot             = dot_q;
        end
    end

    assign tilemap_dots   = dots_q;
    assign dots_remaining = cnt_q;
    assign level_clear    = level_clear_q;

endmodule
